cdb_apb_regbank: RTL and testbench
==================================

# cdb_apb_regbank

APB3 completer on the CDB bus, on the far side of the TAP-to-APB bridge. It accepts JTAG-originated APB transfers issued on `cdb_pclk` and serves them from a small register map: ID, control, status, an error log, a transfer counter and scratch registers. Wait states are programmable. Unmapped and misaligned accesses are logged, because the CDB bus has no `pslverr`. It gives lab/bring-up software a known-good endpoint and a chip-control word.

## Interface
- `NUM_SCRATCH`, 8 — number of scratch registers, 1..64.
- `WAIT_CYCLES`, 1 — wait states inserted in the access phase of every transfer, 0..15.
- `ID_VALUE`, 32'h5443_0001 — value returned by the ID register.
- `cdb_pclk` input 1 — single clock; all logic rises on it.
- `cdb_preset_n` input 1 — reset, synchronous, active-low.
- `cdb_psel` input 1 — APB select.
- `cdb_penable` input 1 — APB enable.
- `cdb_paddr` input 32 — byte address.
- `cdb_pwrite` input 1 — 1 = write.
- `cdb_pwdata` input 32 — write data.
- `cdb_prdata` output 32 — read data.
- `cdb_pready` output 1 — transfer complete.
- `status_in` input 32 — chip status, sampled into the STATUS register.
- `ctrl_out` output 32 — CTRL register contents.

## Operation
- Register map. All registers are word-wide; the address offset is `paddr[11:0]`.
  - 0x000 ID: RO, reads `ID_VALUE`.
  - 0x004 CTRL: RW, reset 0, drives `ctrl_out`.
  - 0x008 STATUS: RO, equals `status_in` registered by one flop every cycle.
  - 0x00C ERR:
    - bit0 UNMAPPED: sticky, write 1 to clear.
    - bit1 MISALIGNED: sticky, write 1 to clear.
    - bits[23:16] ERRCNT: saturates at 255; writing ERR with `pwdata[31]`=1 clears it.
    - All other bits read 0.
  - 0x010 XFER_CNT: RO, 32-bit, wraps, counts every completed transfer.
  - 0x100 + 4*i SCRATCH[i], i < `NUM_SCRATCH`: RW, reset 0.
- Decode:
  - `paddr[31:12]`≠0, or any unlisted offset, is unmapped.
  - `paddr[1:0]`≠0 is misaligned; this check has priority over the unmapped check.
  - An error access reads 32'hDEAD_ADD0. Its write is dropped and the matching sticky bit is set.
  - Writes to RO registers are ignored silently; they are not errors.
- FSM, two states: IDLE and ACCESS.
  - IDLE → ACCESS when `psel`=1 and `penable`=0 (setup phase).
    - On that edge, latch address, direction and write data.
    - On that edge, load the wait counter with `WAIT_CYCLES`.
    - On that edge, capture the decoded read data (or the error pattern) into `cdb_prdata`.
  - In ACCESS, the wait counter decrements each cycle while it is nonzero.
  - `cdb_pready` = (state==ACCESS) && (wcnt==0). It is combinational from registers.
  - Completion edge = ACCESS, pready, psel and penable all high. On that edge:
    - commit the write,
    - update the ERR bits and ERRCNT,
    - increment XFER_CNT,
    - return to IDLE.
  - ACCESS → IDLE without commit or counting if `psel` falls before completion (abort).
  - `psel`&`penable` seen in IDLE (no setup phase) is ignored: the block stays in IDLE and pready stays 0.
- Simultaneous events:
  - A write to ERR clears bits before the same-edge error update. No error can coincide with a mapped ERR write, so W1C always wins.
  - A read of XFER_CNT returns the pre-increment value.
  - A STATUS read returns the sampled value at the setup edge.

## Timing
- Reset values: `cdb_pready` 0, `cdb_prdata` 0, `ctrl_out` 0, all registers 0, state IDLE.
- A transfer with setup at cycle T0 has pready high at cycle T0+1+`WAIT_CYCLES`. Minimum transfer length is 2 cycles (`WAIT_CYCLES`=0).
- `cdb_prdata` is valid from T0+1 and holds until the next setup edge.
- `ctrl_out` changes on the cycle after the completion edge.
- Back-to-back transfers: a setup phase may occur in the cycle right after a completion. There is no dead cycle beyond the APB setup phase.
- Reset asserted mid-ACCESS: IDLE on the next edge, no write commit, counters reset.

## Test plan
- Reset, then read 0x000 with `WAIT_CYCLES`=1 → prdata 32'h5443_0001, pready high exactly 2 cycles after the setup cycle; XFER_CNT then reads 1.
- Write 0x004 = 32'hA5A5_0F0F → `ctrl_out` = 32'hA5A5_0F0F one cycle after completion; readback matches. Then write 0x000 → ID unchanged, ERR = 0.
- Write 0x100+4*(NUM_SCRATCH-1) = 32'h1234_5678, then read 0x100+4*NUM_SCRATCH → first returns written value on readback; second returns 32'hDEAD_ADD0, ERR reads 32'h0001_0001.
- Read 0x006 → 32'hDEAD_ADD0 and ERR bit1 set. Then write ERR = 32'h8000_0003 → ERR reads 0.
- Drop `psel` during the wait state of a write to SCRATCH[0] = 32'hFFFF_FFFF → SCRATCH[0] stays 0 and XFER_CNT does not increment. Assert `cdb_preset_n`=0 mid-ACCESS → pready 0 next cycle and all registers 0.
- 300 back-to-back unmapped reads → ERRCNT saturates at 255 and XFER_CNT = 300.

Source files
------------

// File: rtl/cdb_apb_regbank.sv
// APB3 completer for the CDB bus: ID/CTRL/STATUS/ERR/XFER_CNT plus scratch registers,
// programmable wait states, and error logging in place of pslverr.
module cdb_apb_regbank #(
  parameter int unsigned NUM_SCRATCH = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h5443_0001
) (
  input  logic        cdb_pclk,
  input  logic        cdb_preset_n,
  input  logic        cdb_psel,
  input  logic        cdb_penable,
  input  logic [31:0] cdb_paddr,
  input  logic        cdb_pwrite,
  input  logic [31:0] cdb_pwdata,
  output logic [31:0] cdb_prdata,
  output logic        cdb_pready,
  input  logic [31:0] status_in,
  output logic [31:0] ctrl_out
);

  localparam int unsigned IDX_W     = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam logic [9:0]  SCR_FIRST = 10'd64;
  localparam logic [9:0]  SCR_LAST  = 10'(64 + NUM_SCRATCH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_ADD0;

  typedef enum logic {S_IDLE, S_ACCESS} state_e;
  typedef enum logic [2:0] {
    R_ID, R_CTRL, R_STATUS, R_ERR, R_XCNT, R_SCR, R_BAD_ALIGN, R_BAD_MAP
  } rsel_e;
  typedef struct packed {
    rsel_e             sel;
    logic [IDX_W-1:0]  idx;
  } dec_t;

  // Misalignment is checked first so it wins over the unmapped classification.
  function automatic dec_t decode(input logic [31:0] a);
    dec_t       d;
    logic [9:0] w;
    d.sel = R_BAD_MAP;
    d.idx = '0;
    w     = a[11:2];
    if (a[1:0] != 2'b00) begin
      d.sel = R_BAD_ALIGN;
    end else if (a[31:12] == '0) begin
      case (w)
        10'd0:   d.sel = R_ID;
        10'd1:   d.sel = R_CTRL;
        10'd2:   d.sel = R_STATUS;
        10'd3:   d.sel = R_ERR;
        10'd4:   d.sel = R_XCNT;
        default: begin
          if (w >= SCR_FIRST && w < SCR_LAST) begin
            d.sel = R_SCR;
            d.idx = IDX_W'(w - SCR_FIRST);
          end
        end
      endcase
    end
    return d;
  endfunction

  state_e      state_q;
  logic [3:0]  wcnt_q;
  dec_t        dec_q;
  dec_t        dec_in;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] prdata_q;
  logic [31:0] rdata_d;
  logic [31:0] ctrl_q;
  logic [31:0] status_q;
  logic        unm_q, unm_d;
  logic        mis_q, mis_d;
  logic [7:0]  errcnt_q, errcnt_d;
  logic [31:0] xcnt_q, xcnt_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic        complete;

  assign cdb_pready = (state_q == S_ACCESS) && (wcnt_q == '0);
  assign cdb_prdata = prdata_q;
  assign ctrl_out   = ctrl_q;
  assign complete   = cdb_pready && cdb_psel && cdb_penable;

  always_comb begin
    dec_in  = decode(cdb_paddr);
    rdata_d = ERR_DATA;
    case (dec_in.sel)
      R_ID:     rdata_d = ID_VALUE;
      R_CTRL:   rdata_d = ctrl_q;
      R_STATUS: rdata_d = status_q;
      R_ERR:    rdata_d = {8'h00, errcnt_q, 14'h0000, mis_q, unm_q};
      R_XCNT:   rdata_d = xcnt_q;
      R_SCR:    rdata_d = scratch_q[dec_in.idx];
      default:  rdata_d = ERR_DATA;
    endcase
  end

  // W1C from an ERR write is applied before the error update of the same edge.
  always_comb begin
    unm_d    = unm_q;
    mis_d    = mis_q;
    errcnt_d = errcnt_q;
    xcnt_d   = xcnt_q;
    if (complete) begin
      xcnt_d = xcnt_q + 32'd1;
      if (write_q && dec_q.sel == R_ERR) begin
        if (wdata_q[0])  unm_d    = 1'b0;
        if (wdata_q[1])  mis_d    = 1'b0;
        if (wdata_q[31]) errcnt_d = '0;
      end
      if (dec_q.sel == R_BAD_ALIGN || dec_q.sel == R_BAD_MAP) begin
        if (dec_q.sel == R_BAD_ALIGN) mis_d = 1'b1;
        else                          unm_d = 1'b1;
        if (errcnt_d != 8'hFF) errcnt_d = errcnt_d + 8'd1;
      end
    end
  end

  always_ff @(posedge cdb_pclk) begin
    if (!cdb_preset_n) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      dec_q.sel   <= R_ID;
      dec_q.idx   <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      prdata_q    <= '0;
      ctrl_q      <= '0;
      status_q    <= '0;
      unm_q       <= 1'b0;
      mis_q       <= 1'b0;
      errcnt_q    <= '0;
      xcnt_q      <= '0;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      status_q <= status_in;
      unm_q    <= unm_d;
      mis_q    <= mis_d;
      errcnt_q <= errcnt_d;
      xcnt_q   <= xcnt_d;
      case (state_q)
        S_IDLE: begin
          if (cdb_psel && !cdb_penable) begin
            state_q  <= S_ACCESS;
            wcnt_q   <= WAIT_INIT;
            dec_q    <= dec_in;
            write_q  <= cdb_pwrite;
            wdata_q  <= cdb_pwdata;
            prdata_q <= rdata_d;
          end
        end
        S_ACCESS: begin
          if (!cdb_psel) begin
            state_q <= S_IDLE;
          end else if (complete) begin
            state_q <= S_IDLE;
            if (write_q) begin
              if (dec_q.sel == R_CTRL) ctrl_q <= wdata_q;
              if (dec_q.sel == R_SCR)  scratch_q[dec_q.idx] <= wdata_q;
            end
          end else if (wcnt_q != '0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdb_apb_regbank.sv
// Randomised bench for cdb_apb_regbank against a register-map level reference model.
module tb_cdb_apb_regbank;

  localparam int unsigned NS   = 8;
  localparam int unsigned WT   = 1;
  localparam logic [31:0] IDV  = 32'h5443_0001;
  localparam logic [31:0] DEAD = 32'hDEAD_ADD0;

  logic        clk = 1'b0;
  logic        preset_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata, status_in, ctrl_out;
  logic        pready;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] m_ctrl, m_status, m_xcnt;
  logic [31:0] m_scr [NS];
  logic        m_unm, m_mis;
  int unsigned m_errcnt;

  cdb_apb_regbank #(.NUM_SCRATCH(NS), .WAIT_CYCLES(WT), .ID_VALUE(IDV)) dut (
    .cdb_pclk     (clk),
    .cdb_preset_n (preset_n),
    .cdb_psel     (psel),
    .cdb_penable  (penable),
    .cdb_paddr    (paddr),
    .cdb_pwrite   (pwrite),
    .cdb_pwdata   (pwdata),
    .cdb_prdata   (prdata),
    .cdb_pready   (pready),
    .status_in    (status_in),
    .ctrl_out     (ctrl_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_xcnt = '0; m_unm = 1'b0; m_mis = 1'b0; m_errcnt = 0;
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned off;
    off = a[11:0];
    if (a[1:0] != 2'b00 || a[31:12] != 0) return DEAD;
    if (off == 0)     return IDV;
    if (off == 4)     return m_ctrl;
    if (off == 8)     return m_status;
    if (off == 12)    return {8'h00, 8'(m_errcnt), 14'h0, m_mis, m_unm};
    if (off == 16)    return m_xcnt;
    if (off >= 256 && off < 256 + 4 * NS) return m_scr[(off - 256) / 4];
    return DEAD;
  endfunction

  task automatic model_commit(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    int unsigned off;
    off = a[11:0];
    m_xcnt = m_xcnt + 1;
    if (a[1:0] != 2'b00) begin
      m_mis = 1'b1;
      if (m_errcnt < 255) m_errcnt++;
    end else if (model_read(a) == DEAD && !(off >= 256 && off < 256 + 4 * NS && a[31:12] == 0)) begin
      m_unm = 1'b1;
      if (m_errcnt < 255) m_errcnt++;
    end else if (wr) begin
      if (off == 4) m_ctrl = wd;
      if (off == 12) begin
        if (wd[0])  m_unm = 1'b0;
        if (wd[1])  m_mis = 1'b0;
        if (wd[31]) m_errcnt = 0;
      end
      if (off >= 256) m_scr[(off - 256) / 4] = wd;
    end
  endtask

  task automatic idle(input int unsigned n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // mode: 0 normal, 1 drop psel in the wait state, 2 assert reset in ACCESS
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input int mode, output logic [31:0] rd);
    logic [31:0] exp_rd;
    int unsigned waits;
    exp_rd = model_read(a);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd;
    @(posedge clk); #1;
    rd = prdata;
    if (mode != 0) begin
      check("early_rdata", prdata, exp_rd);
      if (mode == 1) psel = 1'b0;
      else begin penable = 1'b1; preset_n = 1'b0; end
      @(posedge clk); #1;
      check(mode == 1 ? "abort_pready" : "rst_pready", {31'b0, pready}, 32'h0);
      if (mode == 2) begin
        check("rst_prdata", prdata, 32'h0);
        check("rst_ctrl", ctrl_out, 32'h0);
        model_reset();
      end
      preset_n = 1'b1; psel = 1'b0; penable = 1'b0;
      return;
    end
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 20) begin @(posedge clk); #1; waits++; end
    check("latency", waits, WT);
    check("rdata", prdata, exp_rd);
    @(posedge clk); #1;
    model_commit(a, wr, wd);
    check("ctrl_out", ctrl_out, m_ctrl);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic set_status(input logic [31:0] v);
    status_in = v; m_status = v;
    idle(2);
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    int unsigned k;
    preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; status_in = '0; m_status = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pready", {31'b0, pready}, 32'h0);
    check("reset_prdata", prdata, 32'h0);
    check("reset_ctrl", ctrl_out, 32'h0);
    preset_n = 1'b1;
    set_status($urandom());

    xfer(32'h000, 1'b0, '0, 0, rd);
    check("id_read", rd, 32'h5443_0001);
    xfer(32'h010, 1'b0, '0, 0, rd);
    check("xcnt_after_id", rd, 32'd1);

    xfer(32'h004, 1'b1, 32'hA5A5_0F0F, 0, rd);
    check("ctrl_direct", ctrl_out, 32'hA5A5_0F0F);
    xfer(32'h004, 1'b0, '0, 0, rd);
    xfer(32'h000, 1'b1, 32'h1111_2222, 0, rd);
    xfer(32'h000, 1'b0, '0, 0, rd);
    xfer(32'h00C, 1'b0, '0, 0, rd);
    check("err_after_ro_write", rd, 32'h0);

    xfer(32'h100 + 4 * (NS - 1), 1'b1, 32'h1234_5678, 0, rd);
    xfer(32'h100 + 4 * (NS - 1), 1'b0, '0, 0, rd);
    check("scratch_last", rd, 32'h1234_5678);
    xfer(32'h100 + 4 * NS, 1'b0, '0, 0, rd);
    check("scratch_oob", rd, DEAD);
    xfer(32'h00C, 1'b0, '0, 0, rd);
    check("err_unmapped", rd, 32'h0001_0001);

    xfer(32'h006, 1'b0, '0, 0, rd);
    check("misaligned_read", rd, DEAD);
    xfer(32'h00C, 1'b0, '0, 0, rd);
    check("err_misaligned", rd, 32'h0002_0003);
    xfer(32'h00C, 1'b1, 32'h8000_0003, 0, rd);
    xfer(32'h00C, 1'b0, '0, 0, rd);
    check("err_cleared", rd, 32'h0);

    xfer(32'h100, 1'b1, 32'hFFFF_FFFF, 1, rd);
    idle(1);
    xfer(32'h100, 1'b0, '0, 0, rd);
    check("abort_no_commit", rd, 32'h0);
    xfer(32'h010, 1'b0, '0, 0, rd);

    psel = 1'b1; penable = 1'b1; paddr = 32'h004; pwrite = 1'b1; pwdata = 32'hFFFF_0000;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_setup_pready", {31'b0, pready}, 32'h0);
    end
    idle(1);
    xfer(32'h010, 1'b0, '0, 0, rd);
    xfer(32'h004, 1'b0, '0, 0, rd);

    set_status($urandom());
    xfer(32'h008, 1'b0, '0, 0, rd);

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 7);
      case (k)
        0:       a = 32'($urandom_range(0, 4)) * 4;
        1, 2:    a = 32'h100 + 32'($urandom_range(0, NS - 1)) * 4;
        3:       a = 32'h100 + 4 * NS + 32'($urandom_range(0, 40)) * 4;
        4:       begin a = $urandom(); a[11:0] = 12'h004; a[31] = 1'b1; end
        5:       a = 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(1, 3));
        6:       a = 32'h00C;
        default: a = $urandom();
      endcase
      wd = $urandom();
      if ($urandom_range(0, 19) == 0) set_status($urandom());
      xfer(a, 1'($urandom_range(0, 1)), wd, ($urandom_range(0, 15) == 0) ? 1 : 0, rd);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    xfer(32'h108, 1'b1, 32'hCAFE_F00D, 0, rd);
    xfer(32'h108, 1'b1, 32'h0BAD_BEEF, 2, rd);
    idle(2);
    for (int i = 0; i < 5; i++) xfer(32'(i) * 4, 1'b0, '0, 0, rd);
    for (int i = 0; i < NS; i++) begin
      xfer(32'h100 + 32'(i) * 4, 1'b0, '0, 0, rd);
      check("scratch_after_rst", rd, 32'h0);
    end

    preset_n = 1'b0;
    idle(2);
    preset_n = 1'b1;
    model_reset();
    idle(1);
    for (int i = 0; i < 300; i++) xfer(32'h0000_0800 + 32'(i % 8) * 4, 1'b0, '0, 0, rd);
    xfer(32'h010, 1'b0, '0, 0, rd);
    check("xcnt_300", rd, 32'd300);
    xfer(32'h00C, 1'b0, '0, 0, rd);
    check("errcnt_sat", rd, 32'h00FF_0001);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
